// File: rtl/read_arb_qos.sv
// Read-address-channel arbiter with QoS / round-robin selection.
// Holds each grant until the burst's last R beat is accepted.
module read_arb_qos #(
   parameter int NUM_REQ      = 2,
   parameter int ID_WIDTH     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0][3:0]   qos,
   input  logic                      token,
   input  logic                      channel_granted,
   input  logic                      rlast_done,
   output logic                      channel_request,
   output logic [ID_WIDTH-1:0]       selected_slave,
   output logic                      busy
);

   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
   localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_REQ - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_BUSY = 2'd2;

   logic [1:0]          state;
   logic [ID_WIDTH-1:0] last_grant;
   logic [CW-1:0]       wait_cnt [NUM_REQ];
   logic [ID_WIDTH-1:0] win;

   // Pick the winner: starving master first, else RR or QoS order from last_grant+1
   always_comb begin
      logic                starve;
      logic                found;
      logic [3:0]          best_q;
      int                  idx;
      logic [ID_WIDTH-1:0] cand;
      win    = '0;
      starve = 1'b0;
      found  = 1'b0;
      best_q = '0;
      idx    = 0;
      cand   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req[i] && wait_cnt[i] >= LIMIT) begin
            win    = ID_WIDTH'(i);
            starve = 1'b1;
         end
      end
      if (!starve) begin
         for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            cand = ID_WIDTH'(idx);
            if (req[cand]) begin
               if (!found || (!token && qos[cand] > best_q)) begin
                  win    = cand;
                  best_q = qos[cand];
                  found  = 1'b1;
               end
            end
         end
      end
   end

   // Arbitration FSM, handshake tracking and starvation counters
   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= S_IDLE;
         channel_request <= 1'b0;
         busy            <= 1'b0;
         selected_slave  <= '0;
         last_grant      <= LAST_ID;
         for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (|req) begin
                  selected_slave  <= win;
                  channel_request <= 1'b1;
                  state           <= S_REQ;
                  for (int i = 0; i < NUM_REQ; i++) begin
                     if (ID_WIDTH'(i) == win)
                        wait_cnt[i] <= '0;
                     else if (req[i] && wait_cnt[i] < LIMIT)
                        wait_cnt[i] <= wait_cnt[i] + 1'b1;
                     else if (!req[i])
                        wait_cnt[i] <= '0;
                  end
               end
            end
            S_REQ: begin
               if (channel_granted) begin
                  channel_request <= 1'b0;
                  busy            <= 1'b1;
                  last_grant      <= selected_slave;
                  state           <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (rlast_done) begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
            end
            default: begin
               channel_request <= 1'b0;
               busy            <= 1'b0;
               state           <= S_IDLE;
            end
         endcase
      end
   end

endmodule
